// File: rtl/recip_gen.sv
// rtl/recip_gen.sv - restoring-division reciprocal generator, floor(2^NW / N)
// One quotient bit per clock; the constant dividend 2^NW contributes a single 1 bit.
module recip_gen #(
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] n,
  output logic [NW:0]   one_by_n,
  output logic [NW-1:0] rem,
  output logic          div_zero,
  output logic          busy,
  output logic          done
);

  localparam int IW = $clog2(NW + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;

  stateT         state, stateNext;
  logic          accept;
  logic [NW-1:0] nQ;
  logic [NW:0]   r, rShift, rNext, q, qNext;
  logic [IW-1:0] iCnt;
  logic          dBit, ge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // DONE's closing edge also samples start, so jobs can run back-to-back
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        stateNext = IDLE;
        if (start) begin
          accept    = 1'b1;
          stateNext = (n == '0) ? DONE : CALC;
        end
      end
      CALC:    if (iCnt == '0) stateNext = DONE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    dBit   = (iCnt == IW'(NW));
    rShift = (r << 1) | (NW+1)'(dBit);
    ge     = (rShift >= {1'b0, nQ});
    rNext  = ge ? (rShift - {1'b0, nQ}) : rShift;
    qNext  = (q << 1) | (NW+1)'(ge);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nQ       <= '0;
      r        <= '0;
      q        <= '0;
      iCnt     <= '0;
      one_by_n <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (accept) begin
        if (n == '0) begin
          one_by_n <= '1;
          rem      <= '0;
          div_zero <= 1'b1;
        end else begin
          nQ   <= n;
          r    <= '0;
          q    <= '0;
          iCnt <= IW'(NW);
        end
      end else if (state == CALC) begin
        r    <= rNext;
        q    <= qNext;
        iCnt <= iCnt - 1'b1;
        if (iCnt == '0) begin
          one_by_n <= qNext;
          rem      <= rNext[NW-1:0];
          div_zero <= 1'b0;
        end
      end
      busy <= (stateNext != IDLE);
      done <= (stateNext == DONE);
    end
  end

endmodule

// File: tb/tb_recip_gen.sv
// tb/tb_recip_gen.sv - self-checking bench for recip_gen
// Expected values come from plain integer division of 2^16 by N.
module tb_recip_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] n;
  logic [16:0] one_by_n;
  logic [15:0] rem;
  logic        div_zero, busy, done;

  int tests = 0;
  int failed = 0;

  recip_gen #(.NW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n),
    .one_by_n(one_by_n), .rem(rem), .div_zero(div_zero),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] nv;
    logic [16:0] expQ;
    logic [15:0] expR;
    logic        expDz;
  } vecT;

  vecT vecs[7];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model(input logic [15:0] nv, output logic [16:0] q,
                       output logic [15:0] r, output logic dz);
    if (nv == 0) begin
      q = 17'h1FFFF; r = 0; dz = 1'b1;
    end else begin
      q = 17'(65536 / int'(nv));
      r = 16'(65536 % int'(nv));
      dz = 1'b0;
    end
  endtask

  // lat = clock edges after the accepting edge until done is seen high
  task automatic runJob(input logic [15:0] nv, input bit repulse,
                        output int lat, output int busyCyc, output int doneCnt);
    @(negedge clk);
    n = nv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 16'($urandom);
    lat = -1; busyCyc = 0; doneCnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        doneCnt++;
        if (lat < 0) lat = k;
      end
      if (busy) busyCyc++;
      else break;
      if (repulse && (k == 2 || k == 9)) begin
        start = 1'b1; n = 16'd7;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic checkResult(input string tag, input logic [15:0] nv);
    logic [16:0] q; logic [15:0] r; logic dz;
    model(nv, q, r, dz);
    chk({tag, " one_by_n"}, one_by_n, q);
    chk({tag, " rem"}, rem, r);
    chk({tag, " div_zero"}, div_zero, dz);
  endtask

  initial begin
    int lat, busyCyc, doneCnt;
    logic [15:0] nv;

    vecs[0] = '{16'd100,   17'd655,    16'd36, 1'b0};
    vecs[1] = '{16'd1,     17'h10000,  16'd0,  1'b0};
    vecs[2] = '{16'd3,     17'd21845,  16'd1,  1'b0};
    vecs[3] = '{16'd65535, 17'd1,      16'd1,  1'b0};
    vecs[4] = '{16'd32768, 17'd2,      16'd0,  1'b0};
    vecs[5] = '{16'd0,     17'h1FFFF,  16'd0,  1'b1};
    vecs[6] = '{16'd5,     17'd13107,  16'd1,  1'b0};

    rst_n = 1'b0; start = 1'b0; n = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset one_by_n", one_by_n, 0);
    chk("reset rem", rem, 0);
    chk("reset div_zero", div_zero, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      runJob(vecs[v].nv, 1'b0, lat, busyCyc, doneCnt);
      chk($sformatf("vec%0d latency", v), lat, (vecs[v].nv == 0) ? 0 : 17);
      chk($sformatf("vec%0d busy cycles", v), busyCyc, (vecs[v].nv == 0) ? 1 : 18);
      chk($sformatf("vec%0d done count", v), doneCnt, 1);
      chk($sformatf("vec%0d one_by_n", v), one_by_n, vecs[v].expQ);
      chk($sformatf("vec%0d rem", v), rem, vecs[v].expR);
      chk($sformatf("vec%0d div_zero", v), div_zero, vecs[v].expDz);
    end

    for (int t = 0; t < 24; t++) begin
      nv = (t % 3 == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      runJob(nv, 1'b0, lat, busyCyc, doneCnt);
      chk($sformatf("rand n=%0d latency", nv), lat, (nv == 0) ? 0 : 17);
      chk($sformatf("rand n=%0d done count", nv), doneCnt, 1);
      checkResult($sformatf("rand n=%0d", nv), nv);
    end

    // start re-pulsed with n=7 while an n=100 job runs
    runJob(16'd100, 1'b1, lat, busyCyc, doneCnt);
    chk("repulse latency", lat, 17);
    chk("repulse done count", doneCnt, 1);
    chk("repulse busy cycles", busyCyc, 18);
    checkResult("repulse", 16'd100);
    repeat (3) begin
      @(negedge clk);
      chk("repulse no late done", done, 0);
    end

    // asynchronous reset in the middle of an n=3 job
    @(negedge clk);
    n = 16'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset one_by_n", one_by_n, 0);
    chk("midreset rem", rem, 0);
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    repeat (12) begin
      @(negedge clk);
      chk("midreset no done", done, 0);
    end
    rst_n = 1'b1;
    runJob(16'd3, 1'b0, lat, busyCyc, doneCnt);
    chk("postreset latency", lat, 17);
    checkResult("postreset", 16'd3);

    // back-to-back with start held high: n=10 then n=1000
    @(negedge clk);
    n = 16'd10; start = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
    chk("b2b first latency", lat, 17);
    checkResult("b2b first", 16'd10);
    n = 16'd1000;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("b2b busy held", busy, 1);
    chk("b2b done single", done, 0);
    lat = -1;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
    chk("b2b second latency", lat, 17);
    checkResult("b2b second", 16'd1000);
    @(negedge clk);
    chk("b2b busy fall", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
